arbiter_grant_mux: RTL and testbench
====================================

Name: arbiter_grant_mux

Overview:
- Downstream consumer of the weighted-round-robin arbiter.
- Takes the arbiter's one-hot grant_valid and captures the granted requester's payload into a small output FIFO.
- Returns grant_ready to the arbiter to close each grant, and pulses req_ack to the winning requester.
- Presents the captured beats on a valid/ready master stream, tagged with the source index.

Parameters:
- P_REQUESTER_NUM, 3, number of requesters; must match the arbiter's value.
- P_DATA_W, 32, payload width per requester.
- P_BUF_DEPTH, 2, output FIFO depth; power of two, at least 2.

Ports:
- clk  input  1  clock.
- rst  input  1  reset. One clock; reset is asynchronous and active-high.
- grant_valid  input  P_REQUESTER_NUM  one-hot grant from the arbiter. The arbiter holds it until the cycle after grant_ready.
- grant_ready  output  1  grant-complete strobe to the arbiter.
- req_data  input  P_REQUESTER_NUM*P_DATA_W  payloads; requester i occupies [i*P_DATA_W +: P_DATA_W].
- req_ack  output  P_REQUESTER_NUM  one-cycle pulse, one-hot, to the requester whose payload was captured.
- m_data  output  P_DATA_W  FIFO head payload.
- m_src  output  max(1,$clog2(P_REQUESTER_NUM))  FIFO head source index.
- m_valid  output  1  FIFO not empty.
- m_ready  input  1  downstream accept.

Behaviour:
- Reset, asynchronous: FSM goes to S_IDLE, FIFO is emptied. grant_ready=0, req_ack=0, m_valid=0. m_data and m_src are 0.
- Reset asserted mid-grant abandons the grant; no beat is written.

FSM, two states:
- S_IDLE: if grant_valid!=0 and fifo_count<P_BUF_DEPTH at a clock edge:
  - sel = index of lowest set bit of grant_valid;
  - push {sel, req_data[sel]} into the FIFO;
  - go to S_ACK.
- S_IDLE otherwise (grant_valid==0, or FIFO full): stay. Grant is stalled; grant_ready stays 0.
- S_ACK: grant_ready=1 and req_ack[sel]=1, both registered, for exactly this cycle. grant_valid is ignored. Next edge returns unconditionally to S_IDLE.
- At that edge the arbiter clears its grant, so grant_valid is 0 in the following S_IDLE cycle. No double capture is possible.

Timing and throughput:
- Latency: grant_valid seen at edge N. Payload is in the FIFO after edge N. grant_ready/req_ack are high in cycle N+1.
- m_valid is high from cycle N+1 if the FIFO was empty.
- Peak rate is one beat per 3 cycles, set by the arbiter protocol.

Data-hold rule: req_data[sel] is sampled only at the capture edge. The requester must hold it valid while its grant bit is high.

FIFO:
- Standard synchronous FIFO with $clog2(P_BUF_DEPTH)+1-bit count and wrapping read/write pointers.
- Pop when m_valid&&m_ready.
- Push and pop in the same edge leave the count unchanged.
- Full check uses the pre-pop count: a full FIFO with a concurrent pop still stalls capture for that cycle.
- m_data and m_src are driven combinationally from the head entry. Both are held stable while m_valid&&!m_ready.

Boundaries:
- Full FIFO: capture stalls indefinitely. The grant stays open upstream.
- Empty FIFO with m_ready=1: no effect.
- Pointer wrap at P_BUF_DEPTH-1 goes to 0.
- Multi-bit grant_valid: lowest index wins (see optional feature).

Optional Feature:
- ARB_GRANT_CHECK_EN defined:
  - Adds output grant_err (1 bit, reset 0, sticky until reset).
  - grant_err sets on the edge after grant_valid has more than one bit set.
  - grant_err also sets if grant_valid in S_ACK differs from the captured grant.
  - Data path behaviour is unchanged.
- ARB_GRANT_CHECK_EN undefined: no grant_err port and no checking logic. Lowest-index selection still applies.

Test Plan:
- Reset release with grant_valid=0 -> grant_ready, req_ack and m_valid stay 0 for 10 cycles; m_data=0.
- grant_valid=3'b010 at edge 5, req_data[1]=32'hA5A5_0001, m_ready=1 -> cycle 6: grant_ready=1, req_ack=3'b010, m_valid=1, m_data=32'hA5A5_0001, m_src=1. Cycle 7: all strobes 0, FIFO empty.
- m_ready=0, grants 001, 100, 010 issued back-to-back via the real arbiter -> first two are captured (m_src 0 then 2). Third grant stalls with grant_ready=0 until m_ready=1. Afterwards beats drain in order 0, 2, 1.
- Full FIFO with a simultaneous pop and a new grant -> no capture that edge. Capture occurs on the next edge, grant_ready one cycle later.
- Rst pulsed high for 1 cycle during S_ACK -> grant_ready drops immediately; FIFO empty; m_valid=0.
- With ARB_GRANT_CHECK_EN, grant_valid=3'b011 -> req_data[0] captured, m_src=0; grant_err=1 from the next cycle until reset.

Source files
------------

// File: rtl/arbiter_grant_mux.sv
// Grant-to-stream mux: captures the granted requester's payload into a small FIFO and closes the grant.
// Optional ARB_GRANT_CHECK_EN adds a sticky grant_err output flagging malformed or unstable grants.
module arbiter_grant_mux #(
    parameter int P_REQUESTER_NUM = 3,
    parameter int P_DATA_W        = 32,
    parameter int P_BUF_DEPTH     = 2,
    localparam int SRC_W = (P_REQUESTER_NUM > 1) ? $clog2(P_REQUESTER_NUM) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [P_REQUESTER_NUM-1:0]          grant_valid,
    output logic                                grant_ready,
    input  logic [P_REQUESTER_NUM*P_DATA_W-1:0] req_data,
    output logic [P_REQUESTER_NUM-1:0]          req_ack,
    output logic [P_DATA_W-1:0]                 m_data,
    output logic [SRC_W-1:0]                    m_src,
    output logic                                m_valid,
    input  logic                                m_ready,
`ifdef ARB_GRANT_CHECK_EN
    output logic                                grant_err,
`endif
    output logic                                dbg_state
);
    // Handshakes: a beat moves on the m_* stream at a clock edge where m_valid && m_ready;
    // a grant is closed by the single-cycle grant_ready strobe in S_ACK.

    localparam int AW = (P_BUF_DEPTH > 1) ? $clog2(P_BUF_DEPTH) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    state_t                       state, state_nxt;
    logic [P_DATA_W-1:0]          mem_data [P_BUF_DEPTH];
    logic [SRC_W-1:0]             mem_src  [P_BUF_DEPTH];
    logic [AW-1:0]                wr_ptr, rd_ptr;
    logic [AW:0]                  count;
    logic                         full;
    logic                         push, pop;
    logic                         sel_found;
    logic [SRC_W-1:0]             sel;
    logic [P_REQUESTER_NUM-1:0]   sel_onehot;
    logic [P_DATA_W-1:0]          sel_data;
    logic [P_REQUESTER_NUM-1:0]   ack_q;

    // Lowest set bit of the grant wins if the arbiter ever drives more than one.
    always_comb begin
        sel_found  = 1'b0;
        sel        = '0;
        sel_onehot = '0;
        sel_data   = '0;
        for (int i = 0; i < P_REQUESTER_NUM; i++) begin
            if (grant_valid[i] && !sel_found) begin
                sel_found     = 1'b1;
                sel           = SRC_W'(i);
                sel_onehot[i] = 1'b1;
                sel_data      = req_data[i*P_DATA_W +: P_DATA_W];
            end
        end
    end

    // Full is judged on the pre-pop count, so a concurrent pop does not admit a capture.
    assign full    = (count == (AW+1)'(P_BUF_DEPTH));
    assign push    = (state == S_IDLE) && (|grant_valid) && !full;
    assign m_valid = (count != '0);
    assign pop     = m_valid && m_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (push) state_nxt = S_ACK;
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            ack_q <= '0;
        end else begin
            state <= state_nxt;
            ack_q <= push ? sel_onehot : '0;
        end
    end

    assign grant_ready = (state == S_ACK);
    assign req_ack     = ack_q;
    assign dbg_state   = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < P_BUF_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_src[i]  <= '0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= sel_data;
                mem_src[wr_ptr]  <= sel;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign m_data = mem_data[rd_ptr];
    assign m_src  = mem_src[rd_ptr];

`ifdef ARB_GRANT_CHECK_EN
    // Flags multi-hot grants anywhere, and any grant change while the capture is being acknowledged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_err <= 1'b0;
        end else if (((grant_valid & (grant_valid - P_REQUESTER_NUM'(1))) != '0) ||
                     ((state == S_ACK) && (grant_valid != ack_q))) begin
            grant_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_arbiter_grant_mux.sv
// Directed bench for arbiter_grant_mux: inputs change on the falling edge, outputs are checked there too.
module tb_arbiter_grant_mux;
    localparam int N  = 3;
    localparam int W  = 32;
    localparam int SW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     grant_valid;
    logic             grant_ready;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ack;
    logic [W-1:0]     m_data;
    logic [SW-1:0]    m_src;
    logic             m_valid;
    logic             m_ready;
    logic             dbg_state;
`ifdef ARB_GRANT_CHECK_EN
    logic             grant_err;
`endif

    int checks   = 0;
    int failures = 0;
    logic [SW+W-1:0] exp_q[$];
    logic [W-1:0]    dv [N];

    arbiter_grant_mux #(
        .P_REQUESTER_NUM(N),
        .P_DATA_W(W),
        .P_BUF_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .grant_valid(grant_valid),
        .grant_ready(grant_ready),
        .req_data(req_data),
        .req_ack(req_ack),
        .m_data(m_data),
        .m_src(m_src),
        .m_valid(m_valid),
        .m_ready(m_ready),
`ifdef ARB_GRANT_CHECK_EN
        .grant_err(grant_err),
`endif
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_data();
        for (int i = 0; i < N; i++) begin
            dv[i] = $urandom;
            req_data[i*W +: W] = dv[i];
        end
    endtask

    // One clock: the beat about to be accepted at the coming edge is checked against the queue head.
    task automatic cycle();
        logic [SW+W-1:0] e;
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            chk("sb_beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_beat", {m_src, m_data}, e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Arbiter-like grant: hold until grant_ready, keep it through the ack cycle, then clear.
    task automatic arb_grant(input logic [N-1:0] g);
        logic [N-1:0] exp_ack;
        exp_ack = g & (~g + N'(1));
        grant_valid = g;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (grant_ready === 1'b1) break;
        end
        chk("grant_ack_seen", grant_ready, 1);
        chk("grant_req_ack", req_ack, exp_ack);
        cycle();
        grant_valid = '0;
    endtask

    initial begin
        rst         = 1'b1;
        grant_valid = '0;
        m_ready     = 1'b0;
        req_data    = '0;
        new_data();

        @(negedge clk);
        chk("rst_grant_ready", grant_ready, 0);
        chk("rst_req_ack", req_ack, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_src", m_src, 0);
        chk("rst_state", dbg_state, 0);
        rst     = 1'b0;
        m_ready = 1'b1;

        // Idle with an eager consumer: nothing may appear.
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("idle_grant_ready", grant_ready, 0);
            chk("idle_req_ack", req_ack, 0);
            chk("idle_m_valid", m_valid, 0);
        end
        chk("idle_m_data", m_data, 0);

        // Single capture with pass-through.
        req_data[1*W +: W] = 32'hA5A5_0001;
        grant_valid = 3'b010;
        exp_q.push_back({2'd1, 32'hA5A5_0001});
        cycle();
        chk("single_grant_ready", grant_ready, 1);
        chk("single_req_ack", req_ack, 3'b010);
        chk("single_m_valid", m_valid, 1);
        chk("single_m_data", m_data, 32'hA5A5_0001);
        chk("single_m_src", m_src, 1);
        cycle();
        grant_valid = '0;
        chk("single_after_grant_ready", grant_ready, 0);
        chk("single_after_req_ack", req_ack, 0);
        chk("single_after_m_valid", m_valid, 0);

        // Back-pressure: two beats fill the FIFO, the third grant stalls.
        new_data();
        m_ready = 1'b0;
        exp_q.push_back({2'd0, dv[0]});
        arb_grant(3'b001);
        cycle();
        exp_q.push_back({2'd2, dv[2]});
        arb_grant(3'b100);
        cycle();
        chk("full_m_valid", m_valid, 1);
        chk("full_head_src", m_src, 0);
        grant_valid = 3'b010;
        exp_q.push_back({2'd1, dv[1]});
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("stall_grant_ready", grant_ready, 0);
            chk("stall_req_ack", req_ack, 0);
        end
        m_ready = 1'b1;
        cycle();
        chk("full_pop_no_capture", grant_ready, 0);
        cycle();
        chk("stall_release_grant_ready", grant_ready, 1);
        chk("stall_release_req_ack", req_ack, 3'b010);
        chk("stall_release_head_src", m_src, 1);
        cycle();
        grant_valid = '0;
        chk("drain_m_valid", m_valid, 0);

        // Grant and pop arrive together on a full FIFO; pointers wrap here.
        new_data();
        m_ready = 1'b0;
        exp_q.push_back({2'd0, dv[0]});
        arb_grant(3'b001);
        cycle();
        exp_q.push_back({2'd1, dv[1]});
        arb_grant(3'b010);
        cycle();
        grant_valid = 3'b100;
        m_ready     = 1'b1;
        exp_q.push_back({2'd2, dv[2]});
        cycle();
        chk("simul_pop_stall", grant_ready, 0);
        cycle();
        chk("simul_capture", grant_ready, 1);
        chk("simul_req_ack", req_ack, 3'b100);
        cycle();
        grant_valid = '0;
        chk("simul_drain_m_valid", m_valid, 0);

`ifdef ARB_GRANT_CHECK_EN
        chk("err_clear_before", grant_err, 0);
        new_data();
        grant_valid = 3'b011;
        exp_q.push_back({2'd0, dv[0]});
        cycle();
        chk("multi_m_src", m_src, 0);
        chk("multi_m_data", m_data, dv[0]);
        chk("multi_req_ack", req_ack, 3'b001);
        chk("multi_grant_err", grant_err, 1);
        cycle();
        grant_valid = '0;
        cycle();
        chk("multi_grant_err_sticky", grant_err, 1);
`endif

        // Reset during the ack cycle abandons the grant and empties the FIFO.
        new_data();
        m_ready     = 1'b0;
        grant_valid = 3'b100;
        cycle();
        chk("pre_rst_grant_ready", grant_ready, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_grant_ready", grant_ready, 0);
        chk("mid_rst_req_ack", req_ack, 0);
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_m_data", m_data, 0);
        chk("mid_rst_m_src", m_src, 0);
        grant_valid = '0;
        cycle();
        rst = 1'b0;
        cycle();
        chk("post_rst_m_valid", m_valid, 0);
        chk("post_rst_grant_ready", grant_ready, 0);
`ifdef ARB_GRANT_CHECK_EN
        chk("post_rst_grant_err", grant_err, 0);
`endif

        // Normal operation resumes after reset.
        new_data();
        m_ready = 1'b1;
        exp_q.push_back({2'd2, dv[2]});
        arb_grant(3'b100);
        cycle();
        chk("final_m_valid", m_valid, 0);
        chk("sb_drained", 64'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
